// File: rtl/movwide_pkg.sv
// Shared encodings, sizes and helpers for the wide-immediate constant sequencer.
// Optional MOVN path is enabled by defining MOVWIDE_MOVN_EN.
package movwide_pkg;

  localparam int XLEN       = 64;
  localparam int CHUNK_W    = 16;
  localparam int NUM_CHUNKS = 4;

  localparam logic [1:0] OP_MOVZ = 2'b00;
  localparam logic [1:0] OP_MOVK = 2'b01;
  localparam logic [1:0] OP_MOVN = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  function automatic logic [CHUNK_W-1:0] get_chunk(input logic [XLEN-1:0] v, input logic [1:0] idx);
    case (idx)
      2'd0:    get_chunk = v[15:0];
      2'd1:    get_chunk = v[31:16];
      2'd2:    get_chunk = v[47:32];
      2'd3:    get_chunk = v[63:48];
      default: get_chunk = 16'h0000;
    endcase
  endfunction

  // Lowest chunk not marked skip; an all-skip mask starts at chunk 0.
  function automatic logic [1:0] lowest_idx(input logic [NUM_CHUNKS-1:0] skip);
    if (!skip[0])      lowest_idx = 2'd0;
    else if (!skip[1]) lowest_idx = 2'd1;
    else if (!skip[2]) lowest_idx = 2'd2;
    else if (!skip[3]) lowest_idx = 2'd3;
    else               lowest_idx = 2'd0;
  endfunction

  function automatic logic [XLEN-1:0] apply_uop(input logic [XLEN-1:0] acc, input logic [1:0] op,
                                                input logic [CHUNK_W-1:0] imm, input logic [1:0] sh);
    logic [XLEN-1:0] placed;
    logic [XLEN-1:0] mask;
    placed = {48'h0, imm} << {sh, 4'h0};
    mask   = 64'h0000_0000_0000_FFFF << {sh, 4'h0};
    case (op)
      OP_MOVZ: apply_uop = placed;
      OP_MOVK: apply_uop = (acc & ~mask) | placed;
      OP_MOVN: apply_uop = ~placed;
      default: apply_uop = acc;
    endcase
  endfunction

endpackage

// File: rtl/movwide_sequencer_if.sv
// Request / micro-op / completion bundle between decode, the sequencer and the shifter write port.
interface movwide_sequencer_if #(parameter int REG_AW = 5);
  import movwide_pkg::*;

  logic              flush;
  logic              req_valid;
  logic              req_ready;
  logic [XLEN-1:0]   req_value;
  logic [REG_AW-1:0] req_rd;
  logic              uop_valid;
  logic              uop_ready;
  logic [1:0]        uop_op;
  logic [15:0]       uop_imm16;
  logic [1:0]        uop_shamt;
  logic [REG_AW-1:0] uop_rd;
  logic              done;
  logic [XLEN-1:0]   done_value;

  modport master (
    output flush, req_valid, req_value, req_rd, uop_ready,
    input  req_ready, uop_valid, uop_op, uop_imm16, uop_shamt, uop_rd, done, done_value
  );

  modport slave (
    input  flush, req_valid, req_value, req_rd, uop_ready,
    output req_ready, uop_valid, uop_op, uop_imm16, uop_shamt, uop_rd, done, done_value
  );
endinterface

// File: rtl/movwide_chunk_pick.sv
// Finds the next chunk above idx that is not skipped; last=1 when none remains.
module movwide_chunk_pick
  import movwide_pkg::*;
(
  input  logic [NUM_CHUNKS-1:0] skip,
  input  logic [1:0]            idx,
  output logic [1:0]            next_idx,
  output logic                  last
);

  logic [1:0] next_idx_s;
  logic       last_s;

  // Scan downwards so the lowest qualifying chunk is the one left standing.
  always_comb begin
    next_idx_s = idx;
    last_s     = 1'b1;
    for (int i = NUM_CHUNKS - 1; i >= 0; i--) begin
      if ((2'(i) > idx) && !skip[i]) begin
        next_idx_s = 2'(i);
        last_s     = 1'b0;
      end else begin
        next_idx_s = next_idx_s;
        last_s     = last_s;
      end
    end
  end

  assign next_idx = next_idx_s;
  assign last     = last_s;

endmodule

// File: rtl/movwide_sequencer.sv
// Expands a 64-bit constant load into MOVZ/MOVK (MOVN with MOVWIDE_MOVN_EN) micro-ops
// and reports the composed value when the last micro-op is accepted.
module movwide_sequencer
  import movwide_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input logic               clk,
  input logic               rst_n,
  movwide_sequencer_if.slave bus
);

  state_e                state_r, state_s;
  logic [XLEN-1:0]       val_r, val_s, acc_r, acc_s, acc_upd_s;
  logic [XLEN-1:0]       done_value_r, done_value_s;
  logic [NUM_CHUNKS-1:0] skip_r, skip_s, skip_in_s, zero_s;
  logic [1:0]            op_r, op_s, shamt_r, shamt_s;
  logic [1:0]            first_idx_s, first_op_s, next_idx_s;
  logic [CHUNK_W-1:0]    imm_r, imm_s, first_imm_s;
  logic [REG_AW-1:0]     rd_r, rd_s;
  logic                  uop_valid_r, uop_valid_s, done_r, done_s, req_ready_r, req_ready_s;
  logic                  last_s, accept_s, hs_s;

  assign accept_s  = (state_r == ST_IDLE) && req_ready_r && bus.req_valid && !bus.flush;
  assign hs_s      = uop_valid_r && bus.uop_ready;
  assign acc_upd_s = apply_uop(acc_r, op_r, imm_r, shamt_r);

  movwide_chunk_pick u_pick (
    .skip     (skip_r),
    .idx      (shamt_r),
    .next_idx (next_idx_s),
    .last     (last_s)
  );

  // Chunks equal to zero never need a MOVK on the MOVZ path.
  always_comb begin
    zero_s = 4'h0;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      zero_s[i] = (get_chunk(bus.req_value, 2'(i)) == 16'h0000);
    end
  end

`ifdef MOVWIDE_MOVN_EN
  logic [NUM_CHUNKS-1:0] ones_s;
  logic [2:0]            f_cnt_s, z_cnt_s;
  logic                  use_movn_s;

  // Prefer MOVN only when all-ones chunks strictly outnumber all-zero chunks.
  always_comb begin
    ones_s  = 4'h0;
    f_cnt_s = 3'd0;
    z_cnt_s = 3'd0;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      ones_s[i] = (get_chunk(bus.req_value, 2'(i)) == 16'hFFFF);
      f_cnt_s   = f_cnt_s + {2'b00, ones_s[i]};
      z_cnt_s   = z_cnt_s + {2'b00, zero_s[i]};
    end
    use_movn_s  = (f_cnt_s > z_cnt_s);
    skip_in_s   = use_movn_s ? ones_s : zero_s;
    first_idx_s = lowest_idx(skip_in_s);
    first_op_s  = use_movn_s ? OP_MOVN : OP_MOVZ;
    first_imm_s = use_movn_s ? ~get_chunk(bus.req_value, first_idx_s)
                             : get_chunk(bus.req_value, first_idx_s);
  end
`else
  // First micro-op is always a MOVZ of the lowest nonzero chunk.
  always_comb begin
    skip_in_s   = zero_s;
    first_idx_s = lowest_idx(skip_in_s);
    first_op_s  = OP_MOVZ;
    first_imm_s = get_chunk(bus.req_value, first_idx_s);
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_s = state_r;
    if (bus.flush) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  state_s = accept_s ? ST_ISSUE : ST_IDLE;
        ST_ISSUE: state_s = (hs_s && last_s) ? ST_IDLE : ST_ISSUE;
        default:  state_s = ST_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs and datapath; fields hold while stalled.
  always_comb begin
    uop_valid_s  = uop_valid_r;
    op_s         = op_r;
    imm_s        = imm_r;
    shamt_s      = shamt_r;
    rd_s         = rd_r;
    val_s        = val_r;
    skip_s       = skip_r;
    acc_s        = acc_r;
    done_s       = 1'b0;
    done_value_s = done_value_r;
    req_ready_s  = req_ready_r;
    if (bus.flush) begin
      uop_valid_s = 1'b0;
      op_s        = OP_MOVZ;
      imm_s       = 16'h0000;
      shamt_s     = 2'd0;
      rd_s        = {REG_AW{1'b0}};
      acc_s       = 64'h0;
      req_ready_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            val_s       = bus.req_value;
            rd_s        = bus.req_rd;
            skip_s      = skip_in_s;
            uop_valid_s = 1'b1;
            op_s        = first_op_s;
            imm_s       = first_imm_s;
            shamt_s     = first_idx_s;
            req_ready_s = 1'b0;
          end else begin
            req_ready_s = 1'b1;
          end
        end
        ST_ISSUE: begin
          if (hs_s) begin
            acc_s = acc_upd_s;
            if (last_s) begin
              uop_valid_s  = 1'b0;
              op_s         = OP_MOVZ;
              imm_s        = 16'h0000;
              shamt_s      = 2'd0;
              rd_s         = {REG_AW{1'b0}};
              done_s       = 1'b1;
              done_value_s = acc_upd_s;
              req_ready_s  = 1'b1;
            end else begin
              op_s    = OP_MOVK;
              shamt_s = next_idx_s;
              imm_s   = get_chunk(val_r, next_idx_s);
            end
          end else begin
            uop_valid_s = 1'b1;
          end
        end
        default: begin
          uop_valid_s = 1'b0;
          req_ready_s = 1'b1;
        end
      endcase
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uop_valid_r  <= 1'b0;
      op_r         <= OP_MOVZ;
      imm_r        <= 16'h0000;
      shamt_r      <= 2'd0;
      rd_r         <= {REG_AW{1'b0}};
      val_r        <= 64'h0;
      skip_r       <= 4'h0;
      acc_r        <= 64'h0;
      done_r       <= 1'b0;
      done_value_r <= 64'h0;
      req_ready_r  <= 1'b1;
    end else begin
      uop_valid_r  <= uop_valid_s;
      op_r         <= op_s;
      imm_r        <= imm_s;
      shamt_r      <= shamt_s;
      rd_r         <= rd_s;
      val_r        <= val_s;
      skip_r       <= skip_s;
      acc_r        <= acc_s;
      done_r       <= done_s;
      done_value_r <= done_value_s;
      req_ready_r  <= req_ready_s;
    end
  end

  assign bus.req_ready  = req_ready_r;
  assign bus.uop_valid  = uop_valid_r;
  assign bus.uop_op     = op_r;
  assign bus.uop_imm16  = imm_r;
  assign bus.uop_shamt  = shamt_r;
  assign bus.uop_rd     = rd_r;
  assign bus.done       = done_r;
  assign bus.done_value = done_value_r;

endmodule

// File: tb/tb_movwide_sequencer.sv
// Self-checking bench for movwide_sequencer: a chunk-level model predicts the micro-op list
// and final value, a monitor compares every cycle, and directed tests pin literal results.
module tb_movwide_sequencer;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] imm;
    logic [1:0]  sh;
  } uop_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  movwide_sequencer_if #(.REG_AW(5)) bus ();
  movwide_sequencer #(.REG_AW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int checks = 0;
  int failures = 0;
  uop_t exp_q[$];
  uop_t log_q[$];
  logic [63:0] exp_value;
  logic [4:0]  exp_rd;
  bit          exp_active = 1'b0;
  int          done_cnt = 0, hs_cnt = 0, ncyc = 0, acc_n = 0, done_n = 0;
  logic [63:0] last_done_value = 64'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Expected micro-op list from the chunk rules.
  function automatic void model_build(input logic [63:0] v, input logic [4:0] rd);
    logic [15:0] c[4];
    int idx[$];
    bit movn = 1'b0;
    int nf = 0, nz = 0;
    uop_t u;
    for (int i = 0; i < 4; i++) c[i] = v[16*i +: 16];
`ifdef MOVWIDE_MOVN_EN
    for (int i = 0; i < 4; i++) begin
      if (c[i] == 16'hFFFF) nf++;
      if (c[i] == 16'h0000) nz++;
    end
    movn = (nf > nz);
`endif
    for (int i = 0; i < 4; i++)
      if (movn ? (c[i] != 16'hFFFF) : (c[i] != 16'h0000)) idx.push_back(i);
    exp_q.delete();
    log_q.delete();
    if (idx.size() == 0) begin
      u.op = movn ? 2'b10 : 2'b00; u.imm = 16'h0000; u.sh = 2'd0;
      exp_q.push_back(u);
    end else begin
      for (int k = 0; k < idx.size(); k++) begin
        u.op  = (k == 0) ? (movn ? 2'b10 : 2'b00) : 2'b01;
        u.imm = (k == 0 && movn) ? ~c[idx[k]] : c[idx[k]];
        u.sh  = 2'(idx[k]);
        exp_q.push_back(u);
      end
    end
    exp_value  = v;
    exp_rd     = rd;
    exp_active = 1'b1;
  endfunction

  // Per-cycle compare against the model, including stall stability.
  initial begin
    bit   prev_hold = 1'b0;
    uop_t prev_u;
    logic [4:0] prev_rd;
    uop_t cur;
    forever begin
      @(negedge clk);
      cur.op = bus.uop_op; cur.imm = bus.uop_imm16; cur.sh = bus.uop_shamt;
      if (!rst_n) begin
        exp_q.delete();
        exp_active = 1'b0;
        prev_hold  = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("stall_valid", {63'h0, bus.uop_valid}, 64'h1);
          chk("stall_fields", {39'h0, cur, bus.uop_rd}, {39'h0, prev_u, prev_rd});
        end
        if (bus.uop_valid) begin
          if (exp_q.size() == 0) begin
            chk("extra_uop", {63'h0, bus.uop_valid}, 64'h0);
          end else begin
            chk("uop_fields", {44'h0, cur}, {44'h0, exp_q[0]});
            chk("uop_rd", {59'h0, bus.uop_rd}, {59'h0, exp_rd});
            if (bus.uop_ready && !bus.flush) begin
              log_q.push_back(exp_q.pop_front());
              hs_cnt++;
            end
          end
        end
        if (bus.done) begin
          done_cnt++;
          done_n = ncyc;
          last_done_value = bus.done_value;
          if (exp_active && exp_q.size() == 0) begin
            chk("done_value", bus.done_value, exp_value);
            exp_active = 1'b0;
          end else begin
            chk("unexpected_done", {63'h0, bus.done}, 64'h0);
          end
        end
        if (bus.flush) begin
          exp_q.delete();
          exp_active = 1'b0;
        end
        if (bus.req_valid && bus.req_ready && !bus.flush) acc_n = ncyc;
        prev_hold = bus.uop_valid && !bus.uop_ready && !bus.flush;
        prev_u = cur;
        prev_rd = bus.uop_rd;
      end
      ncyc++;
    end
  end

  task automatic send_req(input logic [63:0] v, input logic [4:0] rd);
    int k = 0;
    bus.req_valid = 1'b1;
    bus.req_value = v;
    bus.req_rd = rd;
    while (!bus.req_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_value = ~v;
    bus.req_rd = ~rd;
  endtask

  task automatic run_req(input logic [63:0] v, input logic [4:0] rd, input bit stall);
    int d0 = done_cnt;
    int ph = 0;
    int k = 0;
    model_build(v, rd);
    bus.uop_ready = !stall;
    send_req(v, rd);
    while (done_cnt == d0 && k < 300) begin
      if (stall) begin
        bus.uop_ready = (ph == 3);
        ph = (ph + 1) % 4;
      end
      @(posedge clk); #1;
      k++;
    end
    bus.uop_ready = 1'b1;
    chk("done_once", 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    int d0, h0, k;
    bus.flush = 1'b0; bus.req_valid = 1'b0; bus.req_value = 64'h0; bus.req_rd = 5'd0; bus.uop_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_ready", {63'h0, bus.req_ready}, 64'h1);
    chk("rst_uop_valid", {63'h0, bus.uop_valid}, 64'h0);
    chk("rst_done", {63'h0, bus.done}, 64'h0);
    chk("rst_fields", {39'h0, bus.uop_op, bus.uop_imm16, bus.uop_shamt, bus.uop_rd}, 64'h0);
    chk("rst_done_value", bus.done_value, 64'h0);

    run_req(64'h0000_0000_0000_1234, 5'd7, 1'b0);
    chk("t1_count", 64'(log_q.size()), 64'd1);
    chk("t1_uop0", 64'(log_q[0]), 64'({2'b00, 16'h1234, 2'd0}));
    chk("t1_latency", 64'(done_n - acc_n), 64'd2);
    chk("t1_value", last_done_value, 64'h0000_0000_0000_1234);

    run_req(64'h1234_0000_5678_0000, 5'd12, 1'b0);
    chk("t2_count", 64'(log_q.size()), 64'd2);
    chk("t2_uop0", 64'(log_q[0]), 64'({2'b00, 16'h5678, 2'd1}));
    chk("t2_uop1", 64'(log_q[1]), 64'({2'b01, 16'h1234, 2'd3}));
    chk("t2_latency", 64'(done_n - acc_n), 64'd3);

    run_req(64'h0, 5'd1, 1'b0);
    chk("t3_uop0", 64'(log_q[0]), 64'({2'b00, 16'h0000, 2'd0}));
    chk("t3_value", last_done_value, 64'h0);

    run_req(64'hDEAD_BEEF_CAFE_F00D, 5'd31, 1'b1);
    chk("t4_count", 64'(log_q.size()), 64'd4);
    chk("t4_uop0", 64'(log_q[0]), 64'({2'b00, 16'hF00D, 2'd0}));
    chk("t4_uop1", 64'(log_q[1]), 64'({2'b01, 16'hCAFE, 2'd1}));
    chk("t4_uop2", 64'(log_q[2]), 64'({2'b01, 16'hBEEF, 2'd2}));
    chk("t4_uop3", 64'(log_q[3]), 64'({2'b01, 16'hDEAD, 2'd3}));
    chk("t4_value", last_done_value, 64'hDEAD_BEEF_CAFE_F00D);

    // Flush after the second handshake, with a competing request in the flush cycle.
    model_build(64'h1111_2222_3333_4444, 5'd3);
    d0 = done_cnt; h0 = hs_cnt; k = 0;
    bus.uop_ready = 1'b1;
    send_req(64'h1111_2222_3333_4444, 5'd3);
    while ((hs_cnt - h0) < 2 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("fl_hs", 64'(hs_cnt - h0), 64'd2);
    bus.uop_ready = 1'b0; bus.flush = 1'b1;
    bus.req_valid = 1'b1; bus.req_value = 64'h77; bus.req_rd = 5'd9;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.req_valid = 1'b0; bus.uop_ready = 1'b1;
    chk("fl_valid_drop", {63'h0, bus.uop_valid}, 64'h0);
    chk("fl_req_ready", {63'h0, bus.req_ready}, 64'h1);
    repeat (4) @(posedge clk); #1;
    chk("fl_no_uop", {63'h0, bus.uop_valid}, 64'h0);
    chk("fl_no_done", 64'(done_cnt - d0), 64'd0);

    run_req(64'h5, 5'd4, 1'b0);
    chk("t5_uop0", 64'(log_q[0]), 64'({2'b00, 16'h0005, 2'd0}));
    chk("t5_value", last_done_value, 64'h5);

    run_req(64'hFFFF_FFFF_FFFF_1234, 5'd2, 1'b0);
`ifdef MOVWIDE_MOVN_EN
    chk("t6_count", 64'(log_q.size()), 64'd1);
    chk("t6_uop0", 64'(log_q[0]), 64'({2'b10, 16'hEDCB, 2'd0}));
`else
    chk("t6_count", 64'(log_q.size()), 64'd4);
    chk("t6_uop0", 64'(log_q[0]), 64'({2'b00, 16'h1234, 2'd0}));
    chk("t6_uop3", 64'(log_q[3]), 64'({2'b01, 16'hFFFF, 2'd3}));
`endif
    chk("t6_value", last_done_value, 64'hFFFF_FFFF_FFFF_1234);

    // Asynchronous reset in the middle of a sequence.
    model_build(64'h1111_2222_3333_4444, 5'd5);
    d0 = done_cnt;
    bus.uop_ready = 1'b0;
    send_req(64'h1111_2222_3333_4444, 5'd5);
    chk("mr_valid_before", {63'h0, bus.uop_valid}, 64'h1);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", {63'h0, bus.uop_valid}, 64'h0);
    chk("mr_req_ready", {63'h0, bus.req_ready}, 64'h1);
    chk("mr_fields", {39'h0, bus.uop_op, bus.uop_imm16, bus.uop_shamt, bus.uop_rd}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.uop_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("mr_no_done", 64'(done_cnt - d0), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
